// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use, MDU and dmem wait stalls,
// branch redirect flush and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int GPR_ADDR_W = 5,
    parameter int LU_BUBBLES = 2,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [GPR_ADDR_W-1:0] id_rs1_addr,
    input  logic                  id_rs1_re,
    input  logic [GPR_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs2_re,
    input  logic [GPR_ADDR_W-1:0] id_exe_rd_addr,
    input  logic                  id_exe_rd_we,
    input  logic                  id_exe_mem_re,
    input  logic                  exe_mdu_start,
    input  logic                  mdu_done,
    input  logic                  dmem_req,
    input  logic                  dmem_ack,
    input  logic                  exe_branch_taken,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  id_exe_stall,
    output logic                  exe_mem_stall,
    output logic                  if_id_flush,
    output logic                  id_exe_flush,
    output logic                  exe_mem_bubble,
    output logic [CNT_W-1:0]      stall_cnt
);

    typedef enum logic [1:0] {
        RUN,
        LU_STALL,
        MDU_WAIT,
        MEM_WAIT
    } state_t;

    localparam logic [1:0] LU_LOAD = 2'(LU_BUBBLES - 1);

    state_t     state_q;
    state_t     state_d;
    state_t     ret_q;
    state_t     ret_d;
    logic [1:0] bub_q;
    logic [1:0] bub_d;

    logic ld_ok;
    logic rs1_hit;
    logic rs2_hit;
    logic lu_hit;
    logic mem_wait;

    logic c_pc;
    logic c_ifid;
    logic c_idexe;
    logic c_exemem;
    logic c_ifid_fl;
    logic c_idexe_fl;
    logic c_bubble;

    assign ld_ok = id_exe_mem_re
                 & id_exe_rd_we
                 & (id_exe_rd_addr != '0);

    assign rs1_hit = id_rs1_re
                   & (id_rs1_addr == id_exe_rd_addr);
    assign rs2_hit = id_rs2_re
                   & (id_rs2_addr == id_exe_rd_addr);

    assign lu_hit   = ld_ok & (rs1_hit | rs2_hit);
    assign mem_wait = dmem_req & ~dmem_ack;

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        bub_d      = bub_q;
        c_pc       = 1'b0;
        c_ifid     = 1'b0;
        c_idexe    = 1'b0;
        c_exemem   = 1'b0;
        c_ifid_fl  = 1'b0;
        c_idexe_fl = 1'b0;
        c_bubble   = 1'b0;

        unique case (state_q)
            RUN: begin
                if (mem_wait) begin
                    c_pc     = 1'b1;
                    c_ifid   = 1'b1;
                    c_idexe  = 1'b1;
                    c_exemem = 1'b1;
                    ret_d    = RUN;
                    state_d  = MEM_WAIT;
                end else if (exe_mdu_start) begin
                    if (!mdu_done) begin
                        c_pc     = 1'b1;
                        c_ifid   = 1'b1;
                        c_idexe  = 1'b1;
                        c_bubble = 1'b1;
                        state_d  = MDU_WAIT;
                    end
                end else if (exe_branch_taken) begin
                    c_ifid_fl  = 1'b1;
                    c_idexe_fl = 1'b1;
                end else if (lu_hit) begin
                    c_pc       = 1'b1;
                    c_ifid     = 1'b1;
                    c_idexe_fl = 1'b1;
                    bub_d      = LU_LOAD;
                    if (LU_BUBBLES > 1) begin
                        state_d = LU_STALL;
                    end
                end
            end

            LU_STALL: begin
                // Counter freezes across a dmem wait so no bubble is lost.
                if (mem_wait) begin
                    c_pc     = 1'b1;
                    c_ifid   = 1'b1;
                    c_idexe  = 1'b1;
                    c_exemem = 1'b1;
                    ret_d    = LU_STALL;
                    state_d  = MEM_WAIT;
                end else begin
                    c_pc       = 1'b1;
                    c_ifid     = 1'b1;
                    c_idexe_fl = 1'b1;
                    bub_d      = bub_q - 2'd1;
                    if (bub_q <= 2'd1) begin
                        state_d = RUN;
                    end
                end
            end

            MDU_WAIT: begin
                if (!mdu_done) begin
                    c_pc     = 1'b1;
                    c_ifid   = 1'b1;
                    c_idexe  = 1'b1;
                    c_bubble = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end

            MEM_WAIT: begin
                if (!dmem_ack) begin
                    c_pc     = 1'b1;
                    c_ifid   = 1'b1;
                    c_idexe  = 1'b1;
                    c_exemem = 1'b1;
                end else begin
                    state_d = ret_q;
                end
            end
        endcase
    end

    assign pc_stall       = c_pc & ~rst;
    assign if_id_stall    = c_ifid & ~rst;
    assign id_exe_stall   = c_idexe & ~rst;
    assign exe_mem_stall  = c_exemem & ~rst;
    assign if_id_flush    = c_ifid_fl & ~rst;
    assign id_exe_flush   = c_idexe_fl & ~rst;
    assign exe_mem_bubble = c_bubble & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            ret_q   <= RUN;
            bub_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            bub_q   <= bub_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (pc_stall && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, MDU, branch, dmem wait,
// reset and counter saturation, with hand-computed expectations.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1_addr;
    logic       id_rs1_re;
    logic [4:0] id_rs2_addr;
    logic       id_rs2_re;
    logic [4:0] id_exe_rd_addr;
    logic       id_exe_rd_we;
    logic       id_exe_mem_re;
    logic       exe_mdu_start;
    logic       mdu_done;
    logic       dmem_req;
    logic       dmem_ack;
    logic       exe_branch_taken;

    logic        pc_stall, if_id_stall, id_exe_stall;
    logic        exe_mem_stall, if_id_flush, id_exe_flush;
    logic        exe_mem_bubble;
    logic [31:0] stall_cnt;

    logic [6:0]  l1_ctl;
    logic [31:0] l1_cnt;
    logic [6:0]  s_ctl;
    logic [2:0]  s_cnt;

    logic [6:0] ctl;
    assign ctl = {pc_stall, if_id_stall, id_exe_stall,
                  exe_mem_stall, if_id_flush, id_exe_flush,
                  exe_mem_bubble};

    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] LU   = 7'b1100010;
    localparam logic [6:0] MEM  = 7'b1111000;
    localparam logic [6:0] MDU  = 7'b1110001;
    localparam logic [6:0] BR   = 7'b0000110;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.GPR_ADDR_W(5), .LU_BUBBLES(2), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs1_re(id_rs1_re),
        .id_rs2_addr(id_rs2_addr), .id_rs2_re(id_rs2_re),
        .id_exe_rd_addr(id_exe_rd_addr), .id_exe_rd_we(id_exe_rd_we),
        .id_exe_mem_re(id_exe_mem_re),
        .exe_mdu_start(exe_mdu_start), .mdu_done(mdu_done),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .exe_branch_taken(exe_branch_taken),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .id_exe_stall(id_exe_stall), .exe_mem_stall(exe_mem_stall),
        .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush),
        .exe_mem_bubble(exe_mem_bubble), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.GPR_ADDR_W(5), .LU_BUBBLES(1), .CNT_W(32)) u_lu1 (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs1_re(id_rs1_re),
        .id_rs2_addr(id_rs2_addr), .id_rs2_re(id_rs2_re),
        .id_exe_rd_addr(id_exe_rd_addr), .id_exe_rd_we(id_exe_rd_we),
        .id_exe_mem_re(id_exe_mem_re),
        .exe_mdu_start(exe_mdu_start), .mdu_done(mdu_done),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .exe_branch_taken(exe_branch_taken),
        .pc_stall(l1_ctl[6]), .if_id_stall(l1_ctl[5]),
        .id_exe_stall(l1_ctl[4]), .exe_mem_stall(l1_ctl[3]),
        .if_id_flush(l1_ctl[2]), .id_exe_flush(l1_ctl[1]),
        .exe_mem_bubble(l1_ctl[0]), .stall_cnt(l1_cnt)
    );

    hazard_ctrl #(.GPR_ADDR_W(5), .LU_BUBBLES(2), .CNT_W(3)) u_sat (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs1_re(id_rs1_re),
        .id_rs2_addr(id_rs2_addr), .id_rs2_re(id_rs2_re),
        .id_exe_rd_addr(id_exe_rd_addr), .id_exe_rd_we(id_exe_rd_we),
        .id_exe_mem_re(id_exe_mem_re),
        .exe_mdu_start(exe_mdu_start), .mdu_done(mdu_done),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .exe_branch_taken(exe_branch_taken),
        .pc_stall(s_ctl[6]), .if_id_stall(s_ctl[5]),
        .id_exe_stall(s_ctl[4]), .exe_mem_stall(s_ctl[3]),
        .if_id_flush(s_ctl[2]), .id_exe_flush(s_ctl[1]),
        .exe_mem_bubble(s_ctl[0]), .stall_cnt(s_cnt)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string tag, input logic [6:0] exp);
        #2;
        chk(tag, {25'd0, ctl}, {25'd0, exp});
    endtask

    task automatic idle();
        id_rs1_addr      = '0;
        id_rs1_re        = 1'b0;
        id_rs2_addr      = '0;
        id_rs2_re        = 1'b0;
        id_exe_rd_addr   = '0;
        id_exe_rd_we     = 1'b0;
        id_exe_mem_re    = 1'b0;
        exe_mdu_start    = 1'b0;
        mdu_done         = 1'b0;
        dmem_req         = 1'b0;
        dmem_ack         = 1'b0;
        exe_branch_taken = 1'b0;
    endtask

    task automatic load(input logic [4:0] rd);
        id_exe_mem_re  = 1'b1;
        id_exe_rd_we   = 1'b1;
        id_exe_rd_addr = rd;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #1;
        load(5'd5);
        id_rs1_addr = 5'd5;
        id_rs1_re   = 1'b1;
        look("rst_ctl", NONE);
        tick();
        tick();
        idle();
        rst = 1'b0;
        look("rst_idle", NONE);
        chk("rst_cnt", stall_cnt, 32'd0);

        // load-use on rs1, two bubbles
        load(5'd5);
        id_rs1_addr = 5'd5;
        id_rs1_re   = 1'b1;
        look("lu_b1", LU);
        chk("lu1_b1", {25'd0, l1_ctl}, {25'd0, LU});
        tick();
        idle();
        look("lu_b2", LU);
        chk("lu1_b2", {25'd0, l1_ctl}, {25'd0, NONE});
        tick();
        look("lu_end", NONE);
        chk("lu_cnt", stall_cnt, 32'd2);
        chk("lu1_cnt", l1_cnt, 32'd1);

        // non-hazards
        load(5'd0);
        id_rs1_addr = 5'd0;
        id_rs1_re   = 1'b1;
        look("lu_x0", NONE);
        tick();
        load(5'd5);
        id_rs1_addr = 5'd5;
        id_rs1_re   = 1'b0;
        id_rs2_addr = 5'd5;
        id_rs2_re   = 1'b0;
        look("lu_nore", NONE);
        tick();
        id_exe_mem_re = 1'b0;
        id_rs1_re     = 1'b1;
        look("lu_noload", NONE);
        tick();
        idle();
        chk("lu_nocnt", stall_cnt, 32'd2);

        // MDU: done four cycles after start, branch ignored meanwhile
        exe_mdu_start = 1'b1;
        look("mdu_c0", MDU);
        tick();
        exe_mdu_start = 1'b0;
        look("mdu_c1", MDU);
        tick();
        exe_branch_taken = 1'b1;
        look("mdu_c2br", MDU);
        tick();
        exe_branch_taken = 1'b0;
        look("mdu_c3", MDU);
        tick();
        mdu_done = 1'b1;
        look("mdu_done", NONE);
        tick();
        idle();
        look("mdu_after", NONE);
        chk("mdu_cnt", stall_cnt, 32'd6);
        exe_mdu_start = 1'b1;
        mdu_done      = 1'b1;
        look("mdu_same", NONE);
        tick();
        idle();
        look("mdu_same2", NONE);
        tick();

        // branch beats load-use
        load(5'd9);
        id_rs2_addr      = 5'd9;
        id_rs2_re        = 1'b1;
        exe_branch_taken = 1'b1;
        look("br_lu", BR);
        tick();
        idle();
        look("br_after", NONE);
        chk("br_cnt", stall_cnt, 32'd6);
        tick();

        // dmem wait during the last load-use bubble
        load(5'd7);
        id_rs2_addr = 5'd7;
        id_rs2_re   = 1'b1;
        look("mw_lu", LU);
        tick();
        idle();
        dmem_req = 1'b1;
        look("mw_w1", MEM);
        tick();
        look("mw_w2", MEM);
        tick();
        look("mw_w3", MEM);
        tick();
        dmem_ack = 1'b1;
        look("mw_ack", NONE);
        tick();
        idle();
        look("mw_bub", LU);
        tick();
        look("mw_end", NONE);
        chk("mw_cnt", stall_cnt, 32'd11);

        // reset while in MDU_WAIT
        exe_mdu_start = 1'b1;
        look("rs_start", MDU);
        tick();
        exe_mdu_start = 1'b0;
        look("rs_wait", MDU);
        tick();
        rst = 1'b1;
        look("rs_rst", NONE);
        tick();
        rst = 1'b0;
        look("rs_run", NONE);
        chk("rs_cnt", stall_cnt, 32'd0);
        chk("rs_scnt", {29'd0, s_cnt}, 32'd0);

        // ten stall cycles: 3-bit counter must stick at 7
        exe_mdu_start = 1'b1;
        look("sat_c0", MDU);
        tick();
        exe_mdu_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
        end
        mdu_done = 1'b1;
        look("sat_done", NONE);
        tick();
        idle();
        chk("sat_cnt", stall_cnt, 32'd10);
        chk("sat_scnt", {29'd0, s_cnt}, 32'd7);
        tick();
        chk("sat_hold", {29'd0, s_cnt}, 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core (IF/ID/EXE/MEM/WB).
- Generates per-stage stall/flush/bubble controls for three cases: load-use hazards the EXE forwarding path cannot cover, multi-cycle MDU operations, and data-memory wait states.
- Also applies the branch redirect flush and keeps a saturating stall-cycle counter.
- Sits beside the forwarding logic; its outputs drive the pipeline-register enables and the PC.

Parameters:
- GPR_ADDR_W, 5, register address width (equals `GPR_ADDR_SPACE).
- LU_BUBBLES, 2, bubbles inserted on a load-use hazard; range 1..3.
- CNT_W, 32, width of the stall counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- id_rs1_addr  in  GPR_ADDR_W  rs1 of the instruction in ID.
- id_rs1_re  in  1  ID instruction reads rs1.
- id_rs2_addr  in  GPR_ADDR_W  rs2 of the instruction in ID.
- id_rs2_re  in  1  ID instruction reads rs2.
- id_exe_rd_addr  in  GPR_ADDR_W  rd of the instruction in EXE.
- id_exe_rd_we  in  1  EXE instruction writes rd.
- id_exe_mem_re  in  1  EXE instruction is a load.
- exe_mdu_start  in  1  multi-cycle MUL/DIV issued from EXE this cycle.
- mdu_done  in  1  MDU result valid this cycle (1-cycle pulse).
- dmem_req  in  1  MEM stage has an active data access.
- dmem_ack  in  1  data memory completes the access this cycle.
- exe_branch_taken  in  1  EXE resolves a taken branch or jump.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold IF/ID.
- id_exe_stall  out  1  hold ID/EXE.
- exe_mem_stall  out  1  hold EXE/MEM.
- if_id_flush  out  1  load NOP into IF/ID.
- id_exe_flush  out  1  load NOP into ID/EXE.
- exe_mem_bubble  out  1  load NOP into EXE/MEM.
- stall_cnt  out  CNT_W  cycles in which pc_stall was asserted, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- While rst is high: state=RUN, bubble counter=0, stall_cnt=0, and all control outputs are forced to 0.
- Control outputs are combinational (Mealy) from state and current inputs, so they act in the same cycle. State and counters update on the rising edge of clk.
- States: RUN, LU_STALL, MDU_WAIT, MEM_WAIT.
- Load-use hazard condition (lu_hit):
  - id_exe_mem_re & id_exe_rd_we & (id_exe_rd_addr != 0), and
  - ((id_rs1_re & rs1 == rd) | (id_rs2_re & rs2 == rd)).
- Priority when evaluated in RUN, highest first:
  - mem_wait: dmem_req & ~dmem_ack.
  - exe_mdu_start.
  - exe_branch_taken.
  - lu_hit.
- MEM_WAIT stall set: pc_stall, if_id_stall, id_exe_stall and exe_mem_stall all 1; no flush or bubble outputs asserted.
- MDU_WAIT stall set: pc_stall, if_id_stall, id_exe_stall and exe_mem_bubble all 1.
- RUN:
  - mem_wait: assert the MEM_WAIT stall set; next state MEM_WAIT.
  - exe_mdu_start & ~mdu_done: assert the MDU_WAIT stall set; next state MDU_WAIT.
  - exe_mdu_start & mdu_done in the same cycle: no stall.
  - exe_branch_taken: if_id_flush=1 and id_exe_flush=1; no stall; any lu_hit this cycle is ignored.
  - lu_hit: pc_stall=1, if_id_stall=1, id_exe_flush=1; load bubble counter with LU_BUBBLES-1; next state LU_STALL if LU_BUBBLES>1, else remain RUN.
- LU_STALL:
  - Assert pc_stall, if_id_stall and id_exe_flush; decrement the counter.
  - At counter=0 (this is the last bubble) return to RUN.
  - mem_wait has priority: assert the MEM_WAIT stall set and hold the counter frozen.
- MDU_WAIT:
  - Hold the MDU_WAIT stall set until mdu_done.
  - On the mdu_done cycle, all outputs are 0 and next state is RUN.
  - exe_branch_taken is ignored while in MDU_WAIT.
- MEM_WAIT:
  - Assert the MEM_WAIT stall set while ~dmem_ack.
  - On the ack cycle, deassert everything and return to the state saved on entry (RUN or LU_STALL).
- Flush outputs are never asserted together with exe_mem_stall.
- stall_cnt increments on each cycle with pc_stall=1 and saturates at all-ones.
- rst mid-stall takes effect at the next edge and cancels any pending bubbles.

Test Plan:
1. Load-use, LU_BUBBLES=2: load x5 in EXE with id_rs1_addr=5, id_rs1_re=1 -> pc_stall/if_id_stall/id_exe_flush high for exactly 2 cycles, then all 0; stall_cnt=2.
2. Load to x0 with rs1=0, or rs1 match with id_rs1_re=0 -> no stall; stall_cnt stays 0.
3. MDU: exe_mdu_start, mdu_done 4 cycles later -> pc_stall high 4 cycles, exe_mem_bubble high 4 cycles, all 0 on the done cycle; exe_mdu_start with mdu_done in the same cycle -> no stall.
4. Branch and lu_hit in the same cycle -> if_id_flush=id_exe_flush=1 for 1 cycle, pc_stall=0, state stays RUN.
5. dmem_req held for 3 cycles before dmem_ack, arriving during LU_STALL with 1 bubble left -> all four stalls high 3 cycles, no flush; after ack, the 1 remaining bubble completes; stall_cnt=5 total (2+3).
6. rst asserted in MDU_WAIT -> outputs 0 in the reset cycle, state RUN, stall_cnt=0; stall_cnt preloaded near all-ones saturates and does not wrap.
